// File: rtl/imem_arbiter.sv
// Round-robin arbiter and byte-beat sequencer sharing one byte-wide instruction memory
// between fetch and the loader port. Define IMEM_ARB_MISALIGN_TRAP_EN to reject unaligned requests.
module imem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_valid,
    output logic [31:0]       l_rdata,
    output logic              err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        b;
    logic [ADDR_W-1:0] base;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic              own_l;
    logic              prio_l;

    logic              any_req, win_l, accept, reject;
    logic [ADDR_W-1:0] win_addr;
    logic              capture;
    logic [1:0]        cap_idx;
    logic [31:0]       cap_word;

    always_comb begin
        any_req  = f_req | l_req;
        win_l    = l_req & (~f_req | prio_l);
        win_addr = win_l ? l_addr : f_addr;
`ifdef IMEM_ARB_MISALIGN_TRAP_EN
        reject   = any_req & (win_addr[1:0] != 2'b00);
`else
        reject   = 1'b0;
`endif
        accept   = any_req & ~reject;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = 8'h00;
        f_valid   = 1'b0;
        l_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = BEAT;
            end
            BEAT: begin
                m_en   = 1'b1;
                m_we   = we_q;
                m_addr = base + {{(ADDR_W-2){1'b0}}, b};
                case (b)
                    2'd0:    m_wdata = wdata_q[31:24];
                    2'd1:    m_wdata = wdata_q[23:16];
                    2'd2:    m_wdata = wdata_q[15:8];
                    default: m_wdata = wdata_q[7:0];
                endcase
                if (b == 2'd3) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                f_valid   = ~own_l;
                l_valid   = own_l;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data arrives one cycle behind its beat, so byte b lands on the edge ending beat b+1
    // (or DRAIN for the last byte) and is merged straight into the owner's output word.
    always_comb begin
        capture  = ((state == BEAT) && (b != 2'd0)) || (state == DRAIN);
        cap_idx  = (state == DRAIN) ? 2'd3 : (b - 2'd1);
        cap_word = own_l ? l_rdata : f_rdata;
        case (cap_idx)
            2'd0:    cap_word[31:24] = m_rdata;
            2'd1:    cap_word[23:16] = m_rdata;
            2'd2:    cap_word[15:8]  = m_rdata;
            default: cap_word[7:0]   = m_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            f_gnt   <= 1'b0;
            l_gnt   <= 1'b0;
            err     <= 1'b0;
            prio_l  <= 1'b1;
            own_l   <= 1'b0;
            base    <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            b       <= 2'd0;
            f_rdata <= 32'h0;
            l_rdata <= 32'h0;
        end else begin
            f_gnt <= 1'b0;
            l_gnt <= 1'b0;
            err   <= 1'b0;
            if (state == IDLE && any_req) begin
                f_gnt  <= ~win_l;
                l_gnt  <= win_l;
                err    <= reject;
                prio_l <= ~win_l;
            end
            if (state == IDLE && accept) begin
                own_l   <= win_l;
                base    <= win_addr;
                we_q    <= win_l & l_we;
                wdata_q <= l_wdata;
                b       <= 2'd0;
                if (win_l && l_we) l_rdata <= 32'h0;
            end else if (state == BEAT) begin
                b <= b + 2'd1;
            end
            if (capture && !we_q) begin
                if (own_l) l_rdata <= cap_word;
                else       f_rdata <= cap_word;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed steps plus random traffic against a
// byte-addressed reference memory and a round-robin priority model.
module tb_imem_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              f_req = 1'b0;
    logic [31:0]       f_addr = 32'h0;
    logic              f_gnt, f_valid;
    logic [31:0]       f_rdata;
    logic              l_req = 1'b0;
    logic              l_we = 1'b0;
    logic [31:0]       l_addr = 32'h0;
    logic [31:0]       l_wdata = 32'h0;
    logic              l_gnt, l_valid;
    logic [31:0]       l_rdata;
    logic              err;
    logic              m_en, m_we;
    logic [31:0]       m_addr;
    logic [7:0]        m_wdata;
    logic [7:0]        m_rdata = 8'h00;

    int checks = 0;
    int failures = 0;
    bit exp_prio_l = 1'b1;
    logic [7:0] ref_mem [bit [31:0]];
    bit [7:0]   macro_mem [256];
    int gcyc[$];
    bit gown[$];

    imem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_valid(l_valid), .l_rdata(l_rdata),
        .err(err), .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro stand-in: one-cycle synchronous read, low address byte only.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) macro_mem[m_addr[7:0]] <= m_wdata;
            else      m_rdata <= macro_mem[m_addr[7:0]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] a);
        return {refByte(a), refByte(a + 32'd1), refByte(a + 32'd2), refByte(a + 32'd3)};
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_f_gnt"},   f_gnt,   0);
        checkOutput({tag, "_l_gnt"},   l_gnt,   0);
        checkOutput({tag, "_f_valid"}, f_valid, 0);
        checkOutput({tag, "_l_valid"}, l_valid, 0);
        checkOutput({tag, "_f_rdata"}, f_rdata, 0);
        checkOutput({tag, "_l_rdata"}, l_rdata, 0);
        checkOutput({tag, "_err"},     err,     0);
        checkOutput({tag, "_m_en"},    m_en,    0);
        checkOutput({tag, "_m_we"},    m_we,    0);
        checkOutput({tag, "_m_addr"},  m_addr,  0);
        checkOutput({tag, "_m_wdata"}, {24'h0, m_wdata}, 0);
    endtask

    // Requests are already raised by the caller; the next edge is the sampling edge E0.
    task automatic applyStimulus(input bit is_l, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        logic [31:0] exp_word;
        bit rej;
        exp_word = (is_l && we) ? 32'h0 : refWord(addr);
        rej = 1'b0;
`ifdef IMEM_ARB_MISALIGN_TRAP_EN
        rej = (addr[1:0] != 2'b00);
`endif
        step();
        checkOutput("l_gnt", l_gnt, is_l);
        checkOutput("f_gnt", f_gnt, !is_l);
        checkOutput("err", err, rej);
        exp_prio_l = !is_l;
        if (is_l) begin
            l_req = 1'b0; l_addr = $urandom; l_wdata = $urandom; l_we = 1'($urandom);
        end else begin
            f_req = 1'b0; f_addr = $urandom;
        end
        if (rej) begin
            checkOutput("rej_m_en", m_en, 0);
            step();
            checkOutput("rej_m_en2", m_en, 0);
            checkOutput("rej_valid", {f_valid, l_valid}, 0);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput("m_en", m_en, 1);
            checkOutput("m_we", m_we, we);
            checkOutput("m_addr", m_addr, addr + 32'(k));
            if (we) checkOutput("m_wdata", {24'h0, m_wdata}, (wdata >> (8 * (3 - k))) & 32'hFF);
            step();
        end
        if (we) for (int k = 0; k < 4; k++) ref_mem[addr + 32'(k)] = 8'((wdata >> (8 * (3 - k))) & 32'hFF);
        checkOutput("drain_m_en", m_en, 0);
        checkOutput("drain_valid", {f_valid, l_valid}, 0);
        step();
        checkOutput("own_valid", is_l ? l_valid : f_valid, 1);
        checkOutput("other_valid", is_l ? f_valid : l_valid, 0);
        checkOutput("rdata", is_l ? l_rdata : f_rdata, exp_word);
        step();
    endtask

    task automatic reqL(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
        applyStimulus(1'b1, we, addr, wdata);
    endtask

    task automatic reqF(input logic [31:0] addr);
        f_req = 1'b1; f_addr = addr;
        applyStimulus(1'b0, 1'b0, addr, 32'h0);
    endtask

    // Both sides read at once; the model's pointer decides who is served first.
    task automatic tiePair(input logic [31:0] la, input logic [31:0] fa);
        l_req = 1'b1; l_we = 1'b0; l_addr = la;
        f_req = 1'b1; f_addr = fa;
        if (exp_prio_l) begin
            applyStimulus(1'b1, 1'b0, la, 32'h0);
            applyStimulus(1'b0, 1'b0, fa, 32'h0);
        end else begin
            applyStimulus(1'b0, 1'b0, fa, 32'h0);
            applyStimulus(1'b1, 1'b0, la, 32'h0);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        exp_prio_l = 1'b1;
    endtask

    initial begin
        bit is_l, we;
        logic [31:0] a;

        $display("[TB] reset");
        f_req = 1'b1; l_req = 1'b1;
        step();
        step();
        checkAllZero("reset");
        f_req = 1'b0; l_req = 1'b0;
        rst = 1'b1;

        $display("[TB] directed write and fetch");
        reqL(1'b1, 32'h10, 32'hDEADBEEF);
        reqF(32'h10);
        reqL(1'b0, 32'h10, 32'h0);

        $display("[TB] address wrap");
        reqL(1'b1, 32'hFFFFFFFE, 32'hCAFEF00D);
        reqF(32'hFFFFFFFE);

        $display("[TB] random traffic");
        for (int i = 0; i < 24; i++) begin
            is_l = (i < 8) ? 1'b1 : 1'($urandom);
            we   = (i < 8) ? 1'b1 : (is_l ? 1'($urandom) : 1'b0);
            a    = 32'($urandom_range(0, 123));
            if (is_l) reqL(we, a, $urandom);
            else      reqF(a);
        end
        tiePair(32'h20, 32'h24);
        tiePair(32'h30, 32'h34);

        $display("[TB] continuous tie from reset");
        rst = 1'b0;
        f_req = 1'b1; f_addr = 32'h40;
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h44;
        step();
        step();
        rst = 1'b1;
        for (int c = 0; c < 32; c++) begin
            step();
            if (l_gnt) begin gcyc.push_back(c); gown.push_back(1'b1); end
            if (f_gnt) begin gcyc.push_back(c); gown.push_back(1'b0); end
        end
        checkOutput("tie_count_ge4", gcyc.size() >= 4, 1);
        if (gcyc.size() >= 4) begin
            checkOutput("tie_first_cycle", gcyc[0], 0);
            for (int i = 0; i < 4; i++) begin
                checkOutput("tie_owner", gown[i], (i % 2) == 0);
                if (i > 0) checkOutput("tie_gap", gcyc[i] - gcyc[i-1], 7);
            end
        end
        f_req = 1'b0; l_req = 1'b0;
        doReset();

        $display("[TB] reset during a write");
        reqL(1'b1, 32'h80, 32'hAABBCCDD);
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h80; l_wdata = 32'h11223344;
        step();
        checkOutput("mid_l_gnt", l_gnt, 1);
        l_req = 1'b0;
        step();
        step();
        checkOutput("beat2_addr", m_addr, 32'h82);
        rst = 1'b0;
        step();
        checkAllZero("midrst");
        rst = 1'b1;
        exp_prio_l = 1'b1;
        ref_mem[32'h80] = 8'h11;
        ref_mem[32'h81] = 8'h22;
        ref_mem[32'h82] = 8'h33;
        for (int c = 0; c < 6; c++) begin
            step();
            checkOutput("no_valid_after_rst", {f_valid, l_valid}, 0);
        end
        tiePair(32'h80, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
